// File: rtl/audio_ramp_ctrl.sv
// Audio path run/stop sequencer: ramps signed Q2.14 volume words {right, left}
// toward their effective targets on each sample tick so starts, stops and retargets never click.
module audio_ramp_ctrl #(
   parameter int WIDTH  = 16,
   parameter int STEP_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 req_run,
   input  logic                 tgt_we,
   input  logic [2*WIDTH-1:0]   tgt_vol,
   input  logic [STEP_W-1:0]    step,
   output logic [2*WIDTH-1:0]   cur_vol,
   output logic                 running,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [1:0] {IDLE, RAMP_UP, RUN, RAMP_DN} state_t;

   state_t                state, state_nxt;
   logic [1:0][WIDTH-1:0] tgt, cur, eff, cur_nxt;
   logic                  run_busy_q;
   logic                  done_nxt;

   // One ramp step of c toward e; clamps onto e so it never overshoots or wraps.
   function automatic logic [WIDTH-1:0] ramp_to(input logic [WIDTH-1:0]  c,
                                                input logic [WIDTH-1:0]  e,
                                                input logic [STEP_W-1:0] s);
      logic signed [WIDTH:0] d, mag, s_ext;
      logic [WIDTH-1:0]      s_w;
      s_w   = WIDTH'(s);
      s_ext = $signed({1'b0, s_w});
      d     = $signed({e[WIDTH-1], e}) - $signed({c[WIDTH-1], c});
      mag   = d[WIDTH] ? -d : d;
      if (s == '0 || mag <= s_ext) ramp_to = e;
      else if (d[WIDTH])           ramp_to = c - s_w;
      else                         ramp_to = c + s_w;
   endfunction

   always_comb begin
      eff        = (state == RAMP_UP || state == RUN) ? tgt : '0;
      cur_nxt[0] = ramp_to(cur[0], eff[0], step);
      cur_nxt[1] = ramp_to(cur[1], eff[1], step);
      busy       = (cur[0] != eff[0]) | (cur[1] != eff[1]);
   end

   // NOTE: every output is assigned a default first, so no path through the case can infer a latch.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE:    if (req_run) state_nxt = RAMP_UP;
         RAMP_UP: begin
            if (!req_run) state_nxt = RAMP_DN;
            else if (!busy) begin
               state_nxt = RUN;
               done_nxt  = 1'b1;
            end
         end
         RUN: begin
            if (!req_run) state_nxt = RAMP_DN;
            else if (run_busy_q && !busy) done_nxt = 1'b1;
         end
         RAMP_DN: begin
            if (req_run) state_nxt = RAMP_UP;
            else if (!busy) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments so every register here samples pre-edge values of the others.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         tgt        <= '0;
         cur        <= '0;
         run_busy_q <= 1'b0;
         done       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (tgt_we) tgt <= tgt_vol;
         if (state == IDLE) cur <= '0;
         else if (tick)     cur <= cur_nxt;
         // Remembers a RUN retarget in flight so its completion can raise done.
         run_busy_q <= (state == RUN) && busy;
         done       <= done_nxt;
      end
   end

   assign cur_vol = cur;
   assign running = (state != IDLE);

endmodule

// File: tb/tb_audio_ramp_ctrl.sv
// Self-checking bench for audio_ramp_ctrl: ramp-time table, directed corner sequences,
// and randomized traffic compared every cycle against an integer reference model.
module tb_audio_ramp_ctrl;

   localparam int WIDTH  = 16;
   localparam int STEP_W = 12;

   logic              clk     = 1'b0;
   logic              rst     = 1'b1;
   logic              tick    = 1'b0;
   logic              req_run = 1'b0;
   logic              tgt_we  = 1'b0;
   logic [31:0]       tgt_vol = '0;
   logic [STEP_W-1:0] step    = '0;
   logic [31:0]       cur_vol;
   logic              running, busy, done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   audio_ramp_ctrl #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
      .clk(clk), .rst(rst), .tick(tick), .req_run(req_run), .tgt_we(tgt_we),
      .tgt_vol(tgt_vol), .step(step), .cur_vol(cur_vol), .running(running),
      .busy(busy), .done(done)
   );

   // Reference model: volumes as plain integers, mode as a small phase number.
   localparam int M_OFF = 0, M_UP = 1, M_ON = 2, M_DN = 3;
   int m_mode;
   int m_cur [2];
   int m_tgt [2];
   bit m_done, m_retgt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sx16(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   function automatic int m_eff(input int i);
      return (m_mode == M_UP || m_mode == M_ON) ? m_tgt[i] : 0;
   endfunction

   task automatic model_reset();
      m_mode  = M_OFF;
      m_cur   = '{0, 0};
      m_tgt   = '{0, 0};
      m_done  = 0;
      m_retgt = 0;
   endtask

   // Advances the model by one clock using the inputs the DUT is about to sample.
   task automatic model_step();
      int  e [2];
      int  d, mag, nm;
      bit  at_tgt, dn;
      for (int i = 0; i < 2; i++) e[i] = m_eff(i);
      at_tgt = (m_cur[0] == e[0]) && (m_cur[1] == e[1]);
      nm = m_mode;
      dn = 0;
      case (m_mode)
         M_OFF: if (req_run) nm = M_UP;
         M_UP:  if (!req_run) nm = M_DN; else if (at_tgt) begin nm = M_ON; dn = 1; end
         M_ON:  if (!req_run) nm = M_DN; else if (m_retgt && at_tgt) dn = 1;
         default: if (req_run) nm = M_UP; else if (at_tgt) begin nm = M_OFF; dn = 1; end
      endcase
      m_retgt = (m_mode == M_ON) && !at_tgt;
      for (int i = 0; i < 2; i++) begin
         if (m_mode == M_OFF) m_cur[i] = 0;
         else if (tick) begin
            d   = e[i] - m_cur[i];
            mag = (d < 0) ? -d : d;
            if (step == '0 || mag <= int'(step)) m_cur[i] = e[i];
            else m_cur[i] = m_cur[i] + ((d > 0) ? int'(step) : -int'(step));
         end
      end
      if (tgt_we) begin
         m_tgt[0] = sx16(tgt_vol[15:0]);
         m_tgt[1] = sx16(tgt_vol[31:16]);
      end
      m_mode = nm;
      m_done = dn;
   endtask

   task automatic cycle(input logic tk);
      logic [31:0] exp_vol;
      tick = tk;
      model_step();
      @(posedge clk);
      #1;
      tick = 1'b0;
      exp_vol = {m_cur[1][15:0], m_cur[0][15:0]};
      check("model cur_vol", cur_vol, exp_vol);
      check("model running", 32'(running), 32'(m_mode != M_OFF));
      check("model busy", 32'(busy), 32'((m_cur[0] != m_eff(0)) || (m_cur[1] != m_eff(1))));
      check("model done", 32'(done), 32'(m_done));
   endtask

   task automatic set_tgt(input logic [31:0] v);
      tgt_we  = 1'b1;
      tgt_vol = v;
      cycle(1'b0);
      tgt_we  = 1'b0;
   endtask

   // Ticks every 4th cycle until done; checks tick count and that done lands one cycle after the last tick.
   task automatic run_ramp(input string name, input int exp_ticks);
      int n = 0;
      int last = -1;
      int gap = -1;
      bit got = 0;
      for (int c = 0; c < 4000 && !got; c++) begin
         cycle(c % 4 == 0);
         if (done) begin
            got = 1;
            gap = c - last;
         end else if (c % 4 == 0) begin
            n++;
            last = c;
         end
      end
      check({name, " done seen"}, 32'(got), 32'd1);
      check({name, " ticks"}, n, exp_ticks);
      check({name, " done gap"}, gap, 1);
   endtask

   typedef struct {
      logic [31:0]       vol;
      logic [STEP_W-1:0] stp;
      int                ticks;
   } ramp_vec_t;

   ramp_vec_t vecs [7];
   logic [15:0] neg_seq [6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h4000_4000, 12'h080, 128};
      vecs[1] = '{32'h1000_F000, 12'h300, 6};
      vecs[2] = '{32'h7FFF_8000, 12'hFFF, 9};
      vecs[3] = '{32'h0001_0000, 12'h005, 1};
      vecs[4] = '{32'h2345_1234, 12'h000, 1};
      vecs[5] = '{32'hC000_4000, 12'h040, 256};
      vecs[6] = '{32'h0100_FF00, 12'hFFF, 1};
      neg_seq = '{16'hFD00, 16'hFA00, 16'hF700, 16'hF400, 16'hF100, 16'hF000};

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset cur_vol", cur_vol, 32'h0);
      check("reset running", 32'(running), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);

      // Ramp-time table: up from 0 to target and back down with the same step.
      for (int v = 0; v < 7; v++) begin
         set_tgt(vecs[v].vol);
         step    = vecs[v].stp;
         req_run = 1'b1;
         cycle(1'b0);
         check($sformatf("vec%0d running rise", v), 32'(running), 32'd1);
         run_ramp($sformatf("vec%0d up", v), vecs[v].ticks);
         check($sformatf("vec%0d at target", v), cur_vol, vecs[v].vol);
         req_run = 1'b0;
         cycle(1'b0);
         run_ramp($sformatf("vec%0d down", v), vecs[v].ticks);
         check($sformatf("vec%0d at zero", v), cur_vol, 32'h0);
         check($sformatf("vec%0d idle", v), 32'(running), 32'd0);
      end

      // Start ramp with first-step check, then stop ramp at a coarser step.
      set_tgt(32'h4000_4000);
      step    = 12'h080;
      req_run = 1'b1;
      cycle(1'b0);
      check("start running", 32'(running), 32'd1);
      cycle(1'b1);
      check("start first step", cur_vol, 32'h0080_0080);
      run_ramp("start", 127);
      cycle(1'b0);
      check("start done one cycle", 32'(done), 32'd0);
      step    = 12'h100;
      req_run = 1'b0;
      cycle(1'b0);
      run_ramp("stop", 64);
      check("stop idle", 32'(running), 32'd0);

      // Non-multiple step toward a negative target: last step clamps.
      set_tgt(32'h0000_F000);
      step    = 12'h300;
      req_run = 1'b1;
      cycle(1'b0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1);
         check($sformatf("neg step %0d", i), cur_vol, {16'h0000, neg_seq[i]});
         cycle(1'b0);
         check($sformatf("neg done %0d", i), 32'(done), 32'(i == 5));
      end
      req_run = 1'b0;
      cycle(1'b0);
      run_ramp("neg stop", 6);

      // Reversal from mid ramp-down.
      set_tgt(32'h4000_4000);
      step    = 12'h100;
      req_run = 1'b1;
      cycle(1'b0);
      run_ramp("rev up", 64);
      req_run = 1'b0;
      cycle(1'b0);
      for (int i = 0; i < 32; i++) begin
         cycle(1'b1);
         check("rev running held", 32'(running), 32'd1);
         cycle(1'b0);
      end
      check("rev midpoint", cur_vol, 32'h2000_2000);
      req_run = 1'b1;
      cycle(1'b0);
      check("rev running", 32'(running), 32'd1);
      check("rev busy", 32'(busy), 32'd1);
      run_ramp("rev resume", 32);
      check("rev target", cur_vol, 32'h4000_4000);

      // Retarget in RUN with an immediate jump.
      step    = '0;
      tgt_we  = 1'b1;
      tgt_vol = 32'h1000_4000;
      cycle(1'b0);
      tgt_we  = 1'b0;
      check("retgt busy rise", 32'(busy), 32'd1);
      cycle(1'b0);
      check("retgt busy hold", 32'(busy), 32'd1);
      cycle(1'b1);
      check("retgt jump", cur_vol, 32'h1000_4000);
      check("retgt busy fall", 32'(busy), 32'd0);
      check("retgt no early done", 32'(done), 32'd0);
      cycle(1'b0);
      check("retgt done", 32'(done), 32'd1);
      check("retgt still run", 32'(running), 32'd1);
      cycle(1'b0);
      check("retgt done pulse", 32'(done), 32'd0);

      // Target write on a tick cycle: that tick still uses the old target.
      tgt_we  = 1'b1;
      tgt_vol = 32'h2000_2000;
      cycle(1'b1);
      tgt_we  = 1'b0;
      check("we on tick old tgt", cur_vol, 32'h1000_4000);
      check("we on tick busy", 32'(busy), 32'd1);
      cycle(1'b0);
      cycle(1'b1);
      check("we on tick new tgt", cur_vol, 32'h2000_2000);
      cycle(1'b0);
      check("we on tick done", 32'(done), 32'd1);

      // Asynchronous reset mid ramp-up.
      req_run = 1'b0;
      cycle(1'b0);
      cycle(1'b1);
      cycle(1'b0);
      check("jump stop idle", 32'(running), 32'd0);
      set_tgt(32'h4000_4000);
      step    = 12'h800;
      req_run = 1'b1;
      cycle(1'b0);
      repeat (3) begin
         cycle(1'b1);
         cycle(1'b0);
      end
      check("pre-reset level", cur_vol, 32'h1800_1800);
      rst = 1'b1;
      #1;
      check("async rst cur_vol", cur_vol, 32'h0);
      check("async rst running", 32'(running), 32'd0);
      check("async rst busy", 32'(busy), 32'd0);
      model_reset();
      req_run = 1'b0;
      cycle(1'b0);
      cycle(1'b0);
      rst = 1'b0;
      cycle(1'b0);
      check("post rst idle", 32'(running), 32'd0);
      step    = '0;
      req_run = 1'b1;
      cycle(1'b0);
      cycle(1'b1);
      check("post rst tgt zero", cur_vol, 32'h0);
      check("post rst done", 32'(done), 32'd1);

      // Randomized traffic against the model.
      step = 12'h200;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 99) == 0) req_run = ~req_run;
         tgt_we  = ($urandom_range(0, 199) == 0);
         tgt_vol = $urandom;
         if ($urandom_range(0, 299) == 0)
            step = ($urandom_range(0, 3) == 0) ? '0 : STEP_W'($urandom);
         cycle($urandom_range(0, 2) == 0);
      end
      tgt_we = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
